lsu_mem_port: RTL and testbench

Load/store unit that sits between the RV32I core's memory stage and the word-addressed data memory, and acts as the initiator on that memory's port. It takes byte/halfword/word load and store requests from the core and turns them into word-aligned memory accesses. Sub-word and misaligned stores use read-modify-write, and accesses that span two words are split. Results are returned with a one-cycle done pulse.

---
 rtl/lsu_mem_port_if.sv | 30 +++
 rtl/lsu_mem_port.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_if.sv
// Core-side request/response and memory-side port of the load/store unit.
// The master modport is the LSU; the slave modport is the core plus data memory.
interface lsu_mem_port_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WIDTH  = 32
);
  logic              i_req;
  logic              i_we;
  logic [2:0]        i_funct3;
  logic [ADDR_W-1:0] i_addr;
  logic [WIDTH-1:0]  i_wdata;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic [WIDTH-1:0]  o_rdata;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_we;
  logic [WIDTH-1:0]  o_mem_wdata;
  logic [WIDTH-1:0]  i_mem_rdata;

  modport master (
    input  i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
    output o_busy, o_done, o_err, o_rdata, o_mem_addr, o_mem_we, o_mem_wdata
  );

  modport slave (
    output i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
    input  o_busy, o_done, o_err, o_rdata, o_mem_addr, o_mem_we, o_mem_wdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// RV32I load/store unit: turns byte/half/word requests into word-aligned memory
// accesses, with read-modify-write for partial stores and splitting across words.
module lsu_mem_port #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WIDTH  = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  lsu_mem_port_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, DONE} state_t;

  state_t            state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [WIDTH-1:0]  word0_q;
  logic [WIDTH-1:0]  word1_q;

  function automatic logic acc_legal(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: acc_legal = 1'b1;
      default:                                acc_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   acc_size = 3'd1;
      2'b01:   acc_size = 3'd2;
      default: acc_size = 3'd4;
    endcase
  endfunction

  // Replace the lanes of one word (hi selects word1) that the store bytes land on
  function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] word,
                                                   input logic [WIDTH-1:0] data,
                                                   input logic [1:0] off,
                                                   input logic [2:0] size,
                                                   input logic hi);
    logic [WIDTH-1:0] r;
    logic [2:0]       pos;
    r = word;
    for (int k = 0; k < 4; k++) begin
      pos = 3'(off) + 3'(k);
      if ((3'(k) < size) && (pos[2] == hi))
        r[{pos[1:0], 3'b000} +: 8] = data[8*k +: 8];
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] load_val(input logic [WIDTH-1:0] w0,
                                                input logic [WIDTH-1:0] w1,
                                                input logic [1:0] off,
                                                input logic [2:0] f3);
    logic [2*WIDTH-1:0] pair;
    logic [WIDTH-1:0]   raw;
    pair = {w1, w0} >> {off, 3'b000};
    raw  = pair[WIDTH-1:0];
    case (f3)
      3'b000:  load_val = {{(WIDTH-8){raw[7]}}, raw[7:0]};
      3'b001:  load_val = {{(WIDTH-16){raw[15]}}, raw[15:0]};
      3'b100:  load_val = {{(WIDTH-8){1'b0}}, raw[7:0]};
      3'b101:  load_val = {{(WIDTH-16){1'b0}}, raw[15:0]};
      default: load_val = raw;
    endcase
  endfunction

  logic [1:0]        off;
  logic [2:0]        size;
  logic              span;
  logic [ADDR_W-1:0] word0_addr;
  logic [ADDR_W-1:0] word1_addr;
  logic [ADDR_W-1:0] in_word0_addr;
  logic              in_aligned_sw;
  logic [WIDTH-1:0]  rmw_word0;
  logic [WIDTH-1:0]  ld_result;
  logic [WIDTH-1:0]  wr0_data;
  logic [WIDTH-1:0]  wr1_data;

  // Geometry of the captured request; word1 wraps at the top of the address space
  always_comb begin
    off           = addr_q[1:0];
    size          = acc_size(f3_q);
    span          = (3'(off) + size) > 3'd4;
    word0_addr    = {addr_q[ADDR_W-1:2], 2'b00};
    word1_addr    = word0_addr + ADDR_W'(4);
    in_word0_addr = {bus.i_addr[ADDR_W-1:2], 2'b00};
    in_aligned_sw = bus.i_we && (bus.i_funct3 == 3'b010) && (bus.i_addr[1:0] == 2'b00);
    rmw_word0     = (state == RD0) ? bus.i_mem_rdata : word0_q;
    ld_result     = load_val(rmw_word0, bus.i_mem_rdata, off, f3_q);
    wr0_data      = merge_lanes(rmw_word0, wdata_q, off, size, 1'b0);
    wr1_data      = merge_lanes(word1_q, wdata_q, off, size, 1'b1);
  end

  // FSM with outputs registered for the state being entered
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      we_q            <= 1'b0;
      f3_q            <= 3'b000;
      addr_q          <= '0;
      wdata_q         <= '0;
      word0_q         <= '0;
      word1_q         <= '0;
      bus.o_busy      <= 1'b0;
      bus.o_done      <= 1'b0;
      bus.o_err       <= 1'b0;
      bus.o_rdata     <= '0;
      bus.o_mem_addr  <= '0;
      bus.o_mem_we    <= 1'b0;
      bus.o_mem_wdata <= '0;
    end else begin
      bus.o_done   <= 1'b0;
      bus.o_err    <= 1'b0;
      bus.o_mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_req) begin
            we_q       <= bus.i_we;
            f3_q       <= bus.i_funct3;
            addr_q     <= bus.i_addr;
            wdata_q    <= bus.i_wdata;
            bus.o_busy <= 1'b1;
            if (!acc_legal(bus.i_funct3)) begin
              state      <= DONE;
              bus.o_done <= 1'b1;
              bus.o_err  <= 1'b1;
            end else if (in_aligned_sw) begin
              state           <= WR0;
              bus.o_mem_we    <= 1'b1;
              bus.o_mem_addr  <= in_word0_addr;
              bus.o_mem_wdata <= bus.i_wdata;
            end else begin
              state          <= RD0;
              bus.o_mem_addr <= in_word0_addr;
            end
          end
        end
        RD0: begin
          word0_q <= bus.i_mem_rdata;
          if (span) begin
            state          <= RD1;
            bus.o_mem_addr <= word1_addr;
          end else if (we_q) begin
            state           <= WR0;
            bus.o_mem_we    <= 1'b1;
            bus.o_mem_wdata <= wr0_data;
          end else begin
            state          <= DONE;
            bus.o_done     <= 1'b1;
            bus.o_rdata    <= ld_result;
            bus.o_mem_addr <= '0;
          end
        end
        RD1: begin
          word1_q <= bus.i_mem_rdata;
          if (we_q) begin
            state           <= WR0;
            bus.o_mem_we    <= 1'b1;
            bus.o_mem_addr  <= word0_addr;
            bus.o_mem_wdata <= wr0_data;
          end else begin
            state          <= DONE;
            bus.o_done     <= 1'b1;
            bus.o_rdata    <= ld_result;
            bus.o_mem_addr <= '0;
          end
        end
        WR0: begin
          if (span) begin
            state           <= WR1;
            bus.o_mem_we    <= 1'b1;
            bus.o_mem_addr  <= word1_addr;
            bus.o_mem_wdata <= wr1_data;
          end else begin
            state           <= DONE;
            bus.o_done      <= 1'b1;
            bus.o_mem_addr  <= '0;
            bus.o_mem_wdata <= '0;
          end
        end
        WR1: begin
          state           <= DONE;
          bus.o_done      <= 1'b1;
          bus.o_mem_addr  <= '0;
          bus.o_mem_wdata <= '0;
        end
        DONE: begin
          state      <= IDLE;
          bus.o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: byte-level reference memory model, per-cycle compare
// process, and directed requests with hand-computed results.
module tb_lsu_mem_port;

  logic clk = 1'b0;
  logic rst;
  lsu_mem_port_if bus ();

  lsu_mem_port dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Data memory seen by the DUT: 16 words, aliased over the address space
  logic [31:0] mem [0:15];
  assign bus.i_mem_rdata = mem[bus.o_mem_addr[5:2]];
  always @(posedge clk) if (bus.o_mem_we) mem[bus.o_mem_addr[5:2]] <= bus.o_mem_wdata;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Reference model: byte-addressed memory and expectations for the current request
  logic [7:0]  ref_b [0:63];
  int          m_n;
  logic        m_err;
  logic        m_load;
  logic [31:0] m_new;
  logic [31:0] m_wr [$];
  logic [31:0] exp_rd = 32'h0;

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    int size, off;
    logic legal, span;
    logic [31:0] v;
    legal  = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    size   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off    = int'(a[1:0]);
    span   = (off + size) > 4;
    m_wr.delete();
    m_load = 1'b0;
    m_err  = !legal;
    m_new  = 32'h0;
    if (!legal) begin
      m_n = 1;
    end else if (!we) begin
      m_n = span ? 3 : 2;
      m_load = 1'b1;
      v = 32'h0;
      for (int k = 0; k < size; k++) v[8*k +: 8] = ref_b[6'(a + 32'(k))];
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8*size)) - 32'h1);
      m_new = v;
    end else begin
      m_n = (size == 4 && off == 0) ? 2 : (span ? 5 : 3);
      for (int k = 0; k < size; k++) ref_b[6'(a + 32'(k))] = wd[8*k +: 8];
      m_wr.push_back({a[31:2], 2'b00});
      if (span) m_wr.push_back({a[31:2], 2'b00} + 32'd4);
    end
  endtask

  // Compare process: checks outputs every cycle of an active request
  bit          active = 1'b0;
  int          cyc = 0;
  int          ends = 0;
  int          done_at = 0;
  logic [31:0] addr_at [0:7];
  logic [31:0] wlog [$];

  always @(negedge clk) begin
    if (!active) begin
      cyc = 0;
      done_at = 0;
      wlog.delete();
    end else begin
      cyc++;
      if (cyc <= m_n) begin
        chk("busy", 32'(bus.o_busy), 32'd1);
        chk("done", 32'(bus.o_done), 32'(cyc == m_n));
        if (bus.o_done) done_at = cyc;
        if (cyc == m_n) chk("err", 32'(bus.o_err), 32'(m_err));
        chk("rdata", bus.o_rdata, (cyc == m_n && m_load) ? m_new : exp_rd);
        chk("addr_align", 32'(bus.o_mem_addr[1:0]), 32'd0);
        if (cyc < 8) addr_at[cyc] = bus.o_mem_addr;
        if (bus.o_mem_we) wlog.push_back(bus.o_mem_addr);
      end else if (cyc == m_n + 1) begin
        chk("busy_idle", 32'(bus.o_busy), 32'd0);
        chk("done_idle", 32'(bus.o_done), 32'd0);
        chk("nwrites", 32'(wlog.size()), 32'(m_wr.size()));
        for (int i = 0; i < m_wr.size() && i < wlog.size(); i++) chk("waddr", wlog[i], m_wr[i]);
        for (int w = 0; w < 16; w++)
          chk("mem", mem[w], {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});
        ends++;
      end
    end
  end

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    bus.i_req    = 1'b1;
    bus.i_we     = we;
    bus.i_funct3 = f3;
    bus.i_addr   = a;
    bus.i_wdata  = wd;
  endtask

  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic hold,
                        input logic [31:0] lit_rd, input int lit_n);
    int e0;
    model(we, f3, a, wd);
    drive(we, f3, a, wd);
    @(posedge clk);
    #1;
    e0 = ends;
    active = 1'b1;
    if (!hold) bus.i_req = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #2;
      if (cyc >= m_n) bus.i_req = 1'b0;
      if (ends != e0) break;
    end
    bus.i_req = 1'b0;
    chk("complete", 32'(ends - e0), 32'd1);
    chk("latency", 32'(done_at), 32'(lit_n));
    active = 1'b0;
    if (m_load) exp_rd = m_new;
    chk("rdata_lit", bus.o_rdata, lit_rd);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_busy"},  32'(bus.o_busy), 32'd0);
    chk({tag, "_done"},  32'(bus.o_done), 32'd0);
    chk({tag, "_err"},   32'(bus.o_err), 32'd0);
    chk({tag, "_rdata"}, bus.o_rdata, 32'd0);
    chk({tag, "_we"},    32'(bus.o_mem_we), 32'd0);
    chk({tag, "_addr"},  bus.o_mem_addr, 32'd0);
    chk({tag, "_wdata"}, bus.o_mem_wdata, 32'd0);
  endtask

  // Reset during RD1 of a spanning store: nothing written, outputs cleared at once
  task automatic reset_mid_store();
    m_n = 5; m_err = 1'b0; m_load = 1'b0; m_wr.delete();
    drive(1'b1, 3'b010, 32'h0000_0002, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    active = 1'b1;
    bus.i_req = 1'b0;
    @(posedge clk);
    #1;
    active = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 32'h0;
    chk("rst_mem0", mem[0], 32'h1122_3344);
    chk("rst_mem1", mem[1], 32'hF566_7788);
  endtask

  initial begin
    for (int w = 0; w < 16; w++) mem[w] = 32'h0;
    mem[0]  = 32'h1122_3344;
    mem[1]  = 32'hF566_7788;
    mem[15] = 32'hA1B2_C3D4;
    for (int w = 0; w < 16; w++)
      for (int b = 0; b < 4; b++) ref_b[4*w+b] = mem[w][8*b +: 8];
    rst          = 1'b1;
    bus.i_req    = 1'b0;
    bus.i_we     = 1'b0;
    bus.i_funct3 = 3'b000;
    bus.i_addr   = 32'h0;
    bus.i_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 3'b010, 32'h0000_0000, 32'h0, 1'b0, 32'h1122_3344, 2);
    run_op(1'b0, 3'b000, 32'h0000_0007, 32'h0, 1'b0, 32'hFFFF_FFF5, 2);
    run_op(1'b0, 3'b100, 32'h0000_0007, 32'h0, 1'b0, 32'h0000_00F5, 2);
    run_op(1'b0, 3'b001, 32'h0000_0003, 32'h0, 1'b0, 32'hFFFF_8811, 3);
    chk("lh_addr_rd0", addr_at[1], 32'h0000_0000);
    chk("lh_addr_rd1", addr_at[2], 32'h0000_0004);
    run_op(1'b0, 3'b101, 32'h0000_0003, 32'h0, 1'b0, 32'h0000_8811, 3);
    run_op(1'b0, 3'b011, 32'h0000_0000, 32'h0, 1'b0, 32'h0000_8811, 1);

    reset_mid_store();

    run_op(1'b1, 3'b010, 32'h0000_0002, 32'hDEAD_BEEF, 1'b1, 32'h0, 5);
    chk("sw_span_w0", mem[0], 32'hBEEF_3344);
    chk("sw_span_w1", mem[1], 32'hF566_DEAD);
    run_op(1'b0, 3'b010, 32'h0000_0002, 32'h0, 1'b0, 32'hDEAD_BEEF, 3);
    run_op(1'b1, 3'b000, 32'h0000_0001, 32'h0000_00AB, 1'b0, 32'hDEAD_BEEF, 3);
    chk("sb_w0", mem[0], 32'hBEEF_AB44);
    chk("sb_w1", mem[1], 32'hF566_DEAD);
    run_op(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 1'b0, 32'hAB44_A1B2, 3);
    run_op(1'b1, 3'b010, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 32'hAB44_A1B2, 2);
    chk("sw_aligned", mem[0], 32'hCAFE_F00D);
    run_op(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0, 32'hAB44_A1B2, 5);
    chk("sh_wrap_top", mem[15], 32'h34B2_C3D4);
    chk("sh_wrap_bot", mem[0], 32'hCAFE_F012);
    run_op(1'b0, 3'b100, 32'h0000_0000, 32'h0, 1'b0, 32'h0000_0012, 2);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
